sccpu: RTL and testbench
========================

SCCPU -- requirements
Module: sccpu

Interface
REQ-001 clk  input  1  CPU clock; PC, register file update on rising edge.
REQ-002 rstn  input  1  reset, asynchronous, active-low.
REQ-003 inst  input  32  instruction word fetched from instruction memory at PC, combinational.
REQ-004 DM_rdata  input  32  data-memory read word, combinational from DM_addr.
REQ-005 IM_R  output  1  instruction-memory read enable.
REQ-006 DM_CS  output  1  data-memory chip select.
REQ-007 DM_R  output  1  data-memory read strobe.
REQ-008 DM_W  output  1  data-memory write strobe; memory writes DM_wdata at DM_addr on rising clk while DM_CS&DM_W.
REQ-009 PC  output  32  current program counter (byte address).
REQ-010 ALU_out  output  32  ALU result of current instruction.
REQ-011 DM_addr  output  32  data-memory byte address, equal to ALU_out for lw/sw.
REQ-012 DM_wdata  output  32  store data, equal to rt register value.

Function
REQ-013 Single-cycle MIPS32 subset: each instruction completes in exactly one clk cycle; no pipeline, no stalls, no branch delay slot.
REQ-014 Supported R-type: addu, subu, and, or, xor, nor, slt, sltu, sll, srl, sra, sllv, srlv, srav, jr.
REQ-015 Supported I/J-type: addiu, andi, ori, xori, lui, slti, sltiu, lw, sw, beq, bne, j, jal.
REQ-016 Unsupported opcodes/funct execute as nop: no register write, DM_CS=0, PC+4.
REQ-017 Register file: 32x32, two combinational read ports, one write port written on rising clk; $0 reads 0, writes to $0 discarded.
REQ-018 Arithmetic modulo 2^32, no overflow trap; slt signed, sltu unsigned compare, result 0 or 1.
REQ-019 Immediates: sign-extended for addiu, slti, sltiu, lw, sw, beq/bne offset; zero-extended for andi, ori, xori; lui = imm<<16.
REQ-020 Shifts: sll/srl/sra use shamt; variable shifts use rs[4:0]; sra arithmetic.
REQ-021 Next PC: beq/bne taken -> PC+4+(sext(imm)<<2); j/jal -> {PC+4[31:28], target, 2'b00}; jr -> rs; else PC+4.
REQ-022 jal writes PC+4 to $31 in same cycle.
REQ-023 lw writes DM_rdata to rt; R-type writes rd; other I-type ALU ops write rt.
REQ-024 DM_CS=1 for lw/sw only; DM_R=1 for lw only; DM_W=1 for sw only; all 0 otherwise.
REQ-025 IM_R=1 whenever rstn=1; 0 while rstn=0.
REQ-026 PC increments wrap modulo 2^32.
REQ-027 Address alignment not checked; DM_addr[1:0] passed through unchanged; memory uses word address DM_addr[31:2].

Reset
REQ-028 rstn low asynchronously sets PC=0x00000000 and all 32 registers to 0, independent of clk.
REQ-029 While rstn low: no register write, DM_CS=DM_R=DM_W=0.
REQ-030 Reset asserted mid-program aborts the current instruction; first instruction after release fetches from address 0 on next rising clk boundary.
REQ-031 Data memory contents are not affected by CPU reset.

Verification
REQ-032 Pulse rstn low, then 3 clocks of inst=0x00000000 -> PC 0, 4, 8, 12; DM_CS=0 throughout.
REQ-033 DM[0]=5, DM[4]=7; program lw $1,0($0); lw $2,4($0); addu $3,$1,$2; sw $3,32($0) -> 4th cycle DM_CS=1, DM_W=1, DM_addr=0x20, DM_wdata=12; DM[8]=12 after edge.
REQ-034 addiu $1,$0,-1; sltu $2,$0,$1; slt $3,$0,$1 -> $1=0xFFFFFFFF, $2=1, $3=0; sra $4,$1,4 -> 0xFFFFFFFF.
REQ-035 At PC=0x10 beq $0,$0,-2 -> next PC=0x0C; bne $0,$0,5 -> PC+4.
REQ-036 At PC=0x08 jal 0x40 -> PC=0x100, $31=0x0C; then jr $31 -> PC=0x0C.
REQ-037 addiu $0,$0,9 then addu $5,$0,$0 -> $5=0; assert rstn mid-program -> PC=0 immediately, registers 0.

Source files
------------

// File: rtl/sccpu.sv
// Single-cycle MIPS32 subset core: every instruction completes in one clk cycle.
// Instruction and data memories are external and read combinationally.
module sccpu (
   input  logic        clk,
   input  logic        rstn,
   input  logic [31:0] inst,
   input  logic [31:0] DM_rdata,
   output logic        IM_R,
   output logic        DM_CS,
   output logic        DM_R,
   output logic        DM_W,
   output logic [31:0] PC,
   output logic [31:0] ALU_out,
   output logic [31:0] DM_addr,
   output logic [31:0] DM_wdata
);

   typedef enum logic [3:0] {
      AluAdd, AluSub, AluAnd, AluOr, AluXor, AluNor, AluSlt, AluSltu,
      AluSll, AluSrl, AluSra, AluLui
   } alu_op_e;

   typedef enum logic [1:0] {WbAlu, WbMem, WbLink} wb_sel_e;

   logic [31:0] r_pc;
   logic [31:0] r_rf [32];

   logic [5:0]  w_op;
   logic [5:0]  w_funct;
   logic [4:0]  w_rs;
   logic [4:0]  w_rt;
   logic [4:0]  w_rd;
   logic [4:0]  w_sh;
   logic [15:0] w_imm;

   assign w_op    = inst[31:26];
   assign w_rs    = inst[25:21];
   assign w_rt    = inst[20:16];
   assign w_rd    = inst[15:11];
   assign w_sh    = inst[10:6];
   assign w_funct = inst[5:0];
   assign w_imm   = inst[15:0];

   alu_op_e     w_alu_op;
   wb_sel_e     w_wb_sel;
   logic        w_b_imm;
   logic        w_zext;
   logic        w_var_sh;
   logic        w_we;
   logic [4:0]  w_wa;
   logic        w_mem_r;
   logic        w_mem_w;
   logic        w_beq;
   logic        w_bne;
   logic        w_jmp;
   logic        w_jr;

   // Anything not decoded below falls through the defaults and behaves as a nop.
   always_comb begin
      w_alu_op = AluAdd;
      w_wb_sel = WbAlu;
      w_b_imm  = 1'b0;
      w_zext   = 1'b0;
      w_var_sh = 1'b0;
      w_we     = 1'b0;
      w_wa     = w_rt;
      w_mem_r  = 1'b0;
      w_mem_w  = 1'b0;
      w_beq    = 1'b0;
      w_bne    = 1'b0;
      w_jmp    = 1'b0;
      w_jr     = 1'b0;
      case (w_op)
         6'h00: begin
            w_wa = w_rd;
            w_we = 1'b1;
            case (w_funct)
               6'h21:   w_alu_op = AluAdd;
               6'h23:   w_alu_op = AluSub;
               6'h24:   w_alu_op = AluAnd;
               6'h25:   w_alu_op = AluOr;
               6'h26:   w_alu_op = AluXor;
               6'h27:   w_alu_op = AluNor;
               6'h2A:   w_alu_op = AluSlt;
               6'h2B:   w_alu_op = AluSltu;
               6'h00:   w_alu_op = AluSll;
               6'h02:   w_alu_op = AluSrl;
               6'h03:   w_alu_op = AluSra;
               6'h04:   begin w_alu_op = AluSll; w_var_sh = 1'b1; end
               6'h06:   begin w_alu_op = AluSrl; w_var_sh = 1'b1; end
               6'h07:   begin w_alu_op = AluSra; w_var_sh = 1'b1; end
               6'h08:   begin w_jr = 1'b1; w_we = 1'b0; end
               default: w_we = 1'b0;
            endcase
         end
         6'h09: begin w_alu_op = AluAdd;  w_b_imm = 1'b1; w_we = 1'b1; end
         6'h0A: begin w_alu_op = AluSlt;  w_b_imm = 1'b1; w_we = 1'b1; end
         6'h0B: begin w_alu_op = AluSltu; w_b_imm = 1'b1; w_we = 1'b1; end
         6'h0C: begin w_alu_op = AluAnd;  w_b_imm = 1'b1; w_zext = 1'b1; w_we = 1'b1; end
         6'h0D: begin w_alu_op = AluOr;   w_b_imm = 1'b1; w_zext = 1'b1; w_we = 1'b1; end
         6'h0E: begin w_alu_op = AluXor;  w_b_imm = 1'b1; w_zext = 1'b1; w_we = 1'b1; end
         6'h0F: begin w_alu_op = AluLui;  w_we = 1'b1; end
         6'h23: begin
            w_b_imm  = 1'b1;
            w_we     = 1'b1;
            w_wb_sel = WbMem;
            w_mem_r  = 1'b1;
         end
         6'h2B: begin w_b_imm = 1'b1; w_mem_w = 1'b1; end
         6'h04: begin w_alu_op = AluSub; w_beq = 1'b1; end
         6'h05: begin w_alu_op = AluSub; w_bne = 1'b1; end
         6'h02: w_jmp = 1'b1;
         6'h03: begin
            w_jmp    = 1'b1;
            w_we     = 1'b1;
            w_wa     = 5'd31;
            w_wb_sel = WbLink;
         end
         default: ;
      endcase
   end

   logic [31:0] w_rs_val;
   logic [31:0] w_rt_val;
   logic [31:0] w_ext;
   logic [31:0] w_b;
   logic [4:0]  w_shamt;
   logic [31:0] w_alu;

   assign w_rs_val = (w_rs == 5'd0) ? 32'h0 : r_rf[w_rs];
   assign w_rt_val = (w_rt == 5'd0) ? 32'h0 : r_rf[w_rt];
   assign w_ext    = w_zext ? {16'h0, w_imm} : {{16{w_imm[15]}}, w_imm};
   assign w_b      = w_b_imm ? w_ext : w_rt_val;
   assign w_shamt  = w_var_sh ? w_rs_val[4:0] : w_sh;

   always_comb begin
      w_alu = 32'h0;
      case (w_alu_op)
         AluAdd:  w_alu = w_rs_val + w_b;
         AluSub:  w_alu = w_rs_val - w_b;
         AluAnd:  w_alu = w_rs_val & w_b;
         AluOr:   w_alu = w_rs_val | w_b;
         AluXor:  w_alu = w_rs_val ^ w_b;
         AluNor:  w_alu = ~(w_rs_val | w_b);
         AluSlt:  w_alu = {31'h0, $signed(w_rs_val) < $signed(w_b)};
         AluSltu: w_alu = {31'h0, w_rs_val < w_b};
         AluSll:  w_alu = w_b << w_shamt;
         AluSrl:  w_alu = w_b >> w_shamt;
         AluSra:  w_alu = $unsigned($signed(w_b) >>> w_shamt);
         AluLui:  w_alu = {w_imm, 16'h0};
         default: w_alu = 32'h0;
      endcase
   end

   logic [31:0] w_pc4;
   logic [31:0] w_br_tgt;
   logic        w_taken;
   logic [31:0] w_npc;

   assign w_pc4    = r_pc + 32'd4;
   assign w_br_tgt = w_pc4 + {w_ext[29:0], 2'b00};
   assign w_taken  = (w_beq && (w_rs_val == w_rt_val)) || (w_bne && (w_rs_val != w_rt_val));

   always_comb begin
      w_npc = w_pc4;
      if (w_taken)     w_npc = w_br_tgt;
      else if (w_jmp)  w_npc = {w_pc4[31:28], inst[25:0], 2'b00};
      else if (w_jr)   w_npc = w_rs_val;
   end

   logic [31:0] w_wd;
   logic        w_rf_we;

   always_comb begin
      w_wd = w_alu;
      case (w_wb_sel)
         WbMem:   w_wd = DM_rdata;
         WbLink:  w_wd = w_pc4;
         default: w_wd = w_alu;
      endcase
   end

   assign w_rf_we = w_we && (w_wa != 5'd0);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_pc <= 32'h0;
      end else begin
         r_pc <= w_npc;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < 32; i++) r_rf[i] <= 32'h0;
      end else if (w_rf_we) begin
         r_rf[w_wa] <= w_wd;
      end
   end

   // Memory strobes are forced low for the whole time rstn is asserted.
   assign IM_R     = rstn;
   assign DM_CS    = rstn && (w_mem_r || w_mem_w);
   assign DM_R     = rstn && w_mem_r;
   assign DM_W     = rstn && w_mem_w;
   assign PC       = r_pc;
   assign ALU_out  = w_alu;
   assign DM_addr  = w_alu;
   assign DM_wdata = w_rt_val;

endmodule

// File: tb/tb_sccpu.sv
// Bench for sccpu: directed vector table, hand-written branch/jump/reset sequences,
// then random instructions checked against an instruction-level reference model.
module tb_sccpu;

   logic        clk;
   logic        rstn;
   logic [31:0] inst;
   logic [31:0] DM_rdata;
   logic        IM_R;
   logic        DM_CS;
   logic        DM_R;
   logic        DM_W;
   logic [31:0] PC;
   logic [31:0] ALU_out;
   logic [31:0] DM_addr;
   logic [31:0] DM_wdata;

   sccpu dut (
      .clk      (clk),
      .rstn     (rstn),
      .inst     (inst),
      .DM_rdata (DM_rdata),
      .IM_R     (IM_R),
      .DM_CS    (DM_CS),
      .DM_R     (DM_R),
      .DM_W     (DM_W),
      .PC       (PC),
      .ALU_out  (ALU_out),
      .DM_addr  (DM_addr),
      .DM_wdata (DM_wdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Data memory environment, word addressed, aliased over 4 KiB.
   logic [31:0] dmem [0:1023];
   assign DM_rdata = dmem[DM_addr[11:2]];
   always @(posedge clk) begin
      if (DM_CS && DM_W) dmem[DM_addr[11:2]] <= DM_wdata;
   end

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic apply(input logic [31:0] x);
      inst = x;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference model state
   logic [31:0] m_pc;
   logic [31:0] m_rf [32];
   logic [31:0] m_dm [0:1023];

   task automatic do_reset();
      inst = 32'hAC030020;
      @(negedge clk);
      rstn = 1'b0;
      #2;
      chk("rst pc", PC, 32'h0);
      chk("rst im_r", {31'h0, IM_R}, 32'h0);
      chk("rst dm_cs", {31'h0, DM_CS}, 32'h0);
      chk("rst dm_w", {31'h0, DM_W}, 32'h0);
      @(negedge clk);
      rstn = 1'b1;
      m_pc = 32'h0;
      foreach (m_rf[i]) m_rf[i] = 32'h0;
   endtask

   typedef struct {
      logic [31:0] inst;
      logic [31:0] pc;
      logic [31:0] alu;
      logic [31:0] wdata;
      logic        cs;
      logic        r;
      logic        w;
   } vec_t;

   vec_t vecs [11];

   // One instruction of the reference model: compare DUT outputs, clock, then commit.
   task automatic rand_cycle(input logic [31:0] in);
      logic [5:0]  op;
      logic [5:0]  fn;
      logic [4:0]  sh;
      logic [4:0]  rt;
      logic [31:0] a, b, sx, zx, res, npc, wd;
      logic [4:0]  wa;
      logic        we, chk_alu, cs, rd, wr;
      op = in[31:26];
      fn = in[5:0];
      sh = in[10:6];
      rt = in[20:16];
      a  = m_rf[in[25:21]];
      b  = m_rf[rt];
      sx = {{16{in[15]}}, in[15:0]};
      zx = {16'h0, in[15:0]};
      npc = m_pc + 32'd4;
      res = 32'h0;
      wd = 32'h0;
      wa = rt;
      we = 1'b0;
      chk_alu = 1'b0;
      cs = 1'b0;
      rd = 1'b0;
      wr = 1'b0;
      case (op)
         6'h00: begin
            we = 1'b1;
            chk_alu = 1'b1;
            wa = in[15:11];
            case (fn)
               6'h21: res = a + b;
               6'h23: res = a - b;
               6'h24: res = a & b;
               6'h25: res = a | b;
               6'h26: res = a ^ b;
               6'h27: res = ~(a | b);
               6'h2A: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
               6'h2B: res = (a < b) ? 32'd1 : 32'd0;
               6'h00: res = b << sh;
               6'h02: res = b >> sh;
               6'h03: res = $signed(b) >>> sh;
               6'h04: res = b << a[4:0];
               6'h06: res = b >> a[4:0];
               6'h07: res = $signed(b) >>> a[4:0];
               6'h08: begin npc = a; we = 1'b0; chk_alu = 1'b0; end
               default: begin we = 1'b0; chk_alu = 1'b0; end
            endcase
         end
         6'h09: begin res = a + sx; we = 1'b1; chk_alu = 1'b1; end
         6'h0A: begin res = ($signed(a) < $signed(sx)) ? 32'd1 : 32'd0; we = 1'b1; chk_alu = 1'b1; end
         6'h0B: begin res = (a < sx) ? 32'd1 : 32'd0; we = 1'b1; chk_alu = 1'b1; end
         6'h0C: begin res = a & zx; we = 1'b1; chk_alu = 1'b1; end
         6'h0D: begin res = a | zx; we = 1'b1; chk_alu = 1'b1; end
         6'h0E: begin res = a ^ zx; we = 1'b1; chk_alu = 1'b1; end
         6'h0F: begin res = zx * 32'd65536; we = 1'b1; chk_alu = 1'b1; end
         6'h23: begin res = a + sx; we = 1'b1; chk_alu = 1'b1; cs = 1'b1; rd = 1'b1; end
         6'h2B: begin res = a + sx; chk_alu = 1'b1; cs = 1'b1; wr = 1'b1; end
         6'h04: if (a == b) npc = m_pc + 32'd4 + sx * 32'd4;
         6'h05: if (a != b) npc = m_pc + 32'd4 + sx * 32'd4;
         6'h02: npc = {npc[31:28], in[25:0], 2'b00};
         6'h03: begin
            npc = {npc[31:28], in[25:0], 2'b00};
            we = 1'b1;
            wa = 5'd31;
         end
         default: ;
      endcase
      if (op == 6'h23)      wd = m_dm[res[11:2]];
      else if (op == 6'h03) wd = m_pc + 32'd4;
      else                  wd = res;

      apply(in);
      chk("rnd pc", PC, m_pc);
      chk("rnd im_r", {31'h0, IM_R}, 32'h1);
      chk("rnd dm_cs", {31'h0, DM_CS}, {31'h0, cs});
      chk("rnd dm_r", {31'h0, DM_R}, {31'h0, rd});
      chk("rnd dm_w", {31'h0, DM_W}, {31'h0, wr});
      chk("rnd dm_wdata", DM_wdata, b);
      if (chk_alu) chk("rnd alu", ALU_out, res);
      if (cs) chk("rnd dm_addr", DM_addr, res);
      tick();
      if (wr) m_dm[res[11:2]] = b;
      if (we && wa != 5'd0) m_rf[wa] = wd;
      m_pc = npc;
   endtask

   logic [5:0] fn_tab [0:14];
   logic [5:0] op_tab [0:12];

   function automatic logic [31:0] gen_inst();
      int k;
      logic [4:0] rs, rt, rd, sh;
      k  = $urandom_range(0, 31);
      rs = 5'($urandom_range(0, 7));
      rt = 5'($urandom_range(0, 7));
      rd = 5'($urandom_range(0, 7));
      sh = 5'($urandom_range(0, 31));
      if (k < 15)      return {6'h00, rs, rt, rd, sh, fn_tab[k]};
      else if (k < 28) return {op_tab[k-15], rs, rt, 16'($urandom)};
      else             return $urandom;
   endfunction

   initial begin
      fn_tab = '{6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B,
                 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08};
      op_tab = '{6'h09, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h0A, 6'h0B,
                 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h03};

      vecs[0]  = '{32'h8C010000, 32'd0,  32'h0,        32'h0,        1'b1, 1'b1, 1'b0};
      vecs[1]  = '{32'h8C020004, 32'd4,  32'h4,        32'h0,        1'b1, 1'b1, 1'b0};
      vecs[2]  = '{32'h00221821, 32'd8,  32'd12,       32'd7,        1'b0, 1'b0, 1'b0};
      vecs[3]  = '{32'hAC030020, 32'd12, 32'h20,       32'd12,       1'b1, 1'b0, 1'b1};
      vecs[4]  = '{32'h2401FFFF, 32'd16, 32'hFFFFFFFF, 32'd5,        1'b0, 1'b0, 1'b0};
      vecs[5]  = '{32'h0001102B, 32'd20, 32'd1,        32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
      vecs[6]  = '{32'h0001182A, 32'd24, 32'd0,        32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
      vecs[7]  = '{32'h00012103, 32'd28, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
      vecs[8]  = '{32'h00020000, 32'd32, 32'd1,        32'd1,        1'b0, 1'b0, 1'b0};
      vecs[9]  = '{32'h00030000, 32'd36, 32'd0,        32'd0,        1'b0, 1'b0, 1'b0};
      vecs[10] = '{32'h00040000, 32'd40, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};

      rstn = 1'b0;
      inst = 32'h0;
      foreach (dmem[i]) dmem[i] = 32'h0;
      dmem[0] = 32'd5;
      dmem[1] = 32'd7;

      // Nop stream straight out of reset
      do_reset();
      for (int i = 0; i < 4; i++) begin
         apply(32'h0);
         chk($sformatf("nop pc%0d", i), PC, 32'(4 * i));
         chk($sformatf("nop cs%0d", i), {31'h0, DM_CS}, 32'h0);
         tick();
      end

      // Load/add/store and compare program
      do_reset();
      foreach (vecs[i]) begin
         apply(vecs[i].inst);
         chk($sformatf("vec%0d pc", i), PC, vecs[i].pc);
         chk($sformatf("vec%0d alu", i), ALU_out, vecs[i].alu);
         chk($sformatf("vec%0d wdata", i), DM_wdata, vecs[i].wdata);
         chk($sformatf("vec%0d cs", i), {31'h0, DM_CS}, {31'h0, vecs[i].cs});
         chk($sformatf("vec%0d r", i), {31'h0, DM_R}, {31'h0, vecs[i].r});
         chk($sformatf("vec%0d w", i), {31'h0, DM_W}, {31'h0, vecs[i].w});
         if (vecs[i].cs) chk($sformatf("vec%0d addr", i), DM_addr, vecs[i].alu);
         tick();
      end
      chk("dm word8", dmem[8], 32'd12);

      // Branches from PC 0x10
      do_reset();
      for (int i = 0; i < 4; i++) begin apply(32'h0); tick(); end
      apply(32'h1000FFFE);
      chk("beq pc", PC, 32'h10);
      tick();
      chk("beq target", PC, 32'h0C);
      apply(32'h14000005);
      tick();
      chk("bne fallthru", PC, 32'h10);

      // jal/jr from PC 0x08
      do_reset();
      for (int i = 0; i < 2; i++) begin apply(32'h0); tick(); end
      apply(32'h0C000040);
      chk("jal pc", PC, 32'h08);
      tick();
      chk("jal target", PC, 32'h100);
      apply(32'h001F0000);
      chk("jal link", ALU_out, 32'h0C);
      tick();
      apply(32'h03E00008);
      tick();
      chk("jr target", PC, 32'h0C);

      // $0 stays zero; reset mid-program clears PC and registers at once
      do_reset();
      apply(32'h24000009);
      tick();
      apply(32'h00002821);
      chk("addu zero", ALU_out, 32'h0);
      tick();
      apply(32'h00050000);
      chk("r5 zero", ALU_out, 32'h0);
      tick();
      apply(32'h24060055);
      tick();
      apply(32'h00060000);
      chk("r6 set", ALU_out, 32'h55);
      chk("pc before rst", PC, 32'h10);
      @(posedge clk);
      #2;
      inst = 32'hAC060000;
      rstn = 1'b0;
      #1;
      chk("midrst pc", PC, 32'h0);
      chk("midrst cs", {31'h0, DM_CS}, 32'h0);
      chk("midrst w", {31'h0, DM_W}, 32'h0);
      @(negedge clk);
      rstn = 1'b1;
      apply(32'h00060000);
      chk("postrst pc", PC, 32'h0);
      chk("postrst r6", ALU_out, 32'h0);
      tick();
      chk("postrst pc4", PC, 32'h4);

      // Random instructions against the reference model
      foreach (dmem[i]) dmem[i] = 32'h0;
      foreach (m_dm[i]) m_dm[i] = 32'h0;
      do_reset();
      for (int i = 0; i < 3000; i++) rand_cycle(gen_inst());

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
